// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF       = 16;
  localparam int unsigned DATA_W_DEF       = 16;
  localparam int unsigned STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter onto a single memory port, one transaction in flight.
// Optional fetch starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned DATA_W       = DATA_W_DEF,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data port
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  // memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                drop_q, drop_d;
  logic                fetch_wins;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 2);

  logic [CntW-1:0] starve_q, starve_d;
  logic            starve_hit;

  assign starve_hit = (starve_q == CntW'(STARVE_LIMIT));
  assign fetch_wins = if_req && (!dm_req || starve_hit);

  // Counts consecutive IDLE decisions where fetch was waiting but lost.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IDLE && (if_req || dm_req)) begin
      starve_d = (if_req && !fetch_wins) ? starve_q + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign fetch_wins = if_req && !dm_req;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    drop_d    = drop_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if_gnt    = 1'b0;
    dm_gnt    = 1'b0;
    if_rvalid = 1'b0;
    dm_rvalid = 1'b0;
    if_rdata  = '0;
    dm_rdata  = '0;

    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          state_d = ISSUE;
          if (fetch_wins) begin
            owner_d = OWN_IF;
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end else begin
            owner_d = OWN_DM;
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
          end
        end
      end
      ISSUE: begin
        mem_req   = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (mem_ready) begin
          if (owner_q == OWN_IF) begin
            if_gnt = 1'b1;
          end else begin
            dm_gnt = 1'b1;
          end
          state_d = we_q ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = IDLE;
          if (owner_q == OWN_DM) begin
            dm_rvalid = 1'b1;
            dm_rdata  = mem_rdata;
          end else if (!drop_q && !if_flush) begin
            if_rvalid = 1'b1;
            if_rdata  = mem_rdata;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A flushed fetch still completes on the memory side; only its response is dropped.
    if (owner_q == OWN_IF && state_q != IDLE && if_flush) begin
      drop_d = 1'b1;
    end
    if (state_d == IDLE) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      drop_q  <= drop_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-written corner sequences,
// and a response scoreboard. Test 6 expectations follow MEM_ARB_STARVE_GUARD_EN.
module tb_mem_arbiter;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit Guard = 1'b1;
`else
  localparam bit Guard = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_gnt, if_rvalid;
  logic [15:0] if_addr, if_rdata;
  logic        dm_req, dm_we, dm_gnt, dm_rvalid;
  logic [15:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ready, mem_rvalid;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks   = 0;
  int failures = 0;
  bit mon_en   = 1'b0;

  logic [15:0] if_q[$];
  logic [15:0] dm_q[$];
  logic [15:0] mon_exp;

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [1:0]  exp_gnt;   // {if_gnt, dm_gnt}
    logic        exp_we;
    logic [15:0] exp_addr;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs[6];

  mem_arbiter #(
    .ADDR_W      (16),
    .DATA_W      (16),
    .STARVE_LIMIT(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [79:0] all_outs();
    return {10'd0, mem_req, mem_we, mem_addr, mem_wdata, if_gnt, if_rvalid, if_rdata,
            dm_gnt, dm_rvalid, dm_rdata};
  endfunction

  // Scoreboard: every delivered response must match the oldest expected one.
  always @(negedge clk) begin
    if (mon_en) begin
      if (if_rvalid) begin
        if (if_q.size() == 0) begin
          chk("if_unexpected_rvalid", if_rvalid, 0);
        end else begin
          mon_exp = if_q.pop_front();
          chk("if_rdata_sb", if_rdata, mon_exp);
        end
      end else begin
        chk("if_rdata_idle_zero", if_rdata, 0);
      end
      if (dm_rvalid) begin
        if (dm_q.size() == 0) begin
          chk("dm_unexpected_rvalid", dm_rvalid, 0);
        end else begin
          mon_exp = dm_q.pop_front();
          chk("dm_rdata_sb", dm_rdata, mon_exp);
        end
      end else begin
        chk("dm_rdata_idle_zero", dm_rdata, 0);
      end
    end
  end

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_vec(input vec_t v);
    drive_edge();
    if (v.is_dm) begin
      dm_req = 1'b1; dm_we = v.we; dm_addr = v.addr; dm_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    mem_ready = 1'b1;
    #1;
    chk("vec_idle_no_memreq", mem_req, 0);
    drive_edge();
    #1;
    chk("vec_mem_req", mem_req, 1);
    chk("vec_mem_we", mem_we, v.exp_we);
    chk("vec_mem_addr", mem_addr, v.exp_addr);
    if (v.we) chk("vec_mem_wdata", mem_wdata, v.wdata);
    chk("vec_gnt", {if_gnt, dm_gnt}, v.exp_gnt);
    drive_edge();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; dm_wdata = '0;
    if (!v.we) begin
      if (v.is_dm) dm_q.push_back(v.exp_rdata);
      else if_q.push_back(v.exp_rdata);
      mem_rvalid = 1'b1; mem_rdata = v.rdata;
      #1;
      chk("vec_rvalid_timing", v.is_dm ? dm_rvalid : if_rvalid, 1);
      drive_edge();
      mem_rvalid = 1'b0; mem_rdata = '0;
    end
  endtask

  // mode 0: flush while stalled in ISSUE; 1: flush in WAIT before data; 2: flush with data
  task automatic fetch_flush(input int mode);
    drive_edge();
    if_req = 1'b1; if_addr = 16'h0080 + 16'(mode); mem_ready = (mode != 0);
    drive_edge();
    if (mode == 0) begin
      if_flush = 1'b1;
      #1;
      chk("flush_stall_no_gnt", if_gnt, 0);
      drive_edge();
      if_flush = 1'b0; mem_ready = 1'b1;
    end
    #1;
    chk("flush_gnt", if_gnt, 1);
    drive_edge();
    if_req = 1'b0;
    if (mode == 1) begin
      if_flush = 1'b1;
      drive_edge();
      if_flush = 1'b0;
    end
    if (mode == 2) if_flush = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 16'h1357;
    #1;
    chk("flush_rvalid_dropped", if_rvalid, 0);
    chk("flush_rdata_zero", if_rdata, 0);
    drive_edge();
    mem_rvalid = 1'b0; mem_rdata = '0; if_flush = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    logic exp_if;
    vecs[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 2'b10, 1'b0, 16'h0040, 16'hBEEF};
    vecs[1] = '{1'b1, 1'b0, 16'h0200, 16'h9999, 16'h5A5A, 2'b01, 1'b0, 16'h0200, 16'h5A5A};
    vecs[2] = '{1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 16'h0000, 2'b01, 1'b1, 16'hFFFF, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'h0000, 16'h0001, 16'h0000, 2'b01, 1'b1, 16'h0000, 16'h0000};
    vecs[4] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'h0000, 2'b10, 1'b0, 16'hFFFE, 16'h0000};
    vecs[5] = '{1'b1, 1'b0, 16'h8001, 16'h4444, 16'hFFFF, 2'b01, 1'b0, 16'h8001, 16'hFFFF};

    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0; dm_req = 0; dm_we = 0;
    dm_addr = 0; dm_wdata = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("reset_outputs_zero", all_outs(), 0);
    mon_en = 1'b1;

    // Test 1 is vecs[0]; the rest of the table covers both ports and address extremes.
    for (int i = 0; i < 6; i++) do_vec(vecs[i]);

    // Test 2: simultaneous requests, data write wins, fetch follows.
    drive_edge();
    if_req = 1'b1; if_addr = 16'h0300;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0100; dm_wdata = 16'h1234; mem_ready = 1'b1;
    drive_edge();
    #1;
    chk("prio_mem_we", mem_we, 1);
    chk("prio_mem_addr", mem_addr, 16'h0100);
    chk("prio_mem_wdata", mem_wdata, 16'h1234);
    chk("prio_gnt", {if_gnt, dm_gnt}, 2'b01);
    drive_edge();
    dm_req = 1'b0; dm_we = 1'b0;
    #1;
    chk("prio_idle_gap", mem_req, 0);
    drive_edge();
    #1;
    chk("prio_fetch_addr", mem_addr, 16'h0300);
    chk("prio_fetch_we", mem_we, 0);
    chk("prio_fetch_gnt", {if_gnt, dm_gnt}, 2'b10);
    drive_edge();
    if_req = 1'b0;
    if_q.push_back(16'hC0DE);
    mem_rvalid = 1'b1; mem_rdata = 16'hC0DE;
    drive_edge();
    mem_rvalid = 1'b0; mem_rdata = '0;

    // Test 3: memory stall; fields held from capture, stray mem_rvalid ignored.
    drive_edge();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0A0A; mem_ready = 1'b0;
    drive_edge();
    for (int i = 0; i < 3; i++) begin
      dm_addr = 16'h1111;
      mem_rvalid = (i == 1); mem_rdata = 16'h7777;
      #1;
      chk("stall_mem_req", mem_req, 1);
      chk("stall_mem_addr", mem_addr, 16'h0A0A);
      chk("stall_no_gnt", {if_gnt, dm_gnt}, 2'b00);
      chk("stall_no_rvalid", dm_rvalid, 0);
      drive_edge();
    end
    mem_rvalid = 1'b0; mem_ready = 1'b1;
    #1;
    chk("stall_release_gnt", dm_gnt, 1);
    chk("stall_release_addr", mem_addr, 16'h0A0A);
    drive_edge();
    dm_req = 1'b0; if_flush = 1'b1;
    dm_q.push_back(16'h2468);
    mem_rvalid = 1'b1; mem_rdata = 16'h2468;
    #1;
    chk("dm_ignores_flush", dm_rvalid, 1);
    drive_edge();
    mem_rvalid = 1'b0; mem_rdata = '0; if_flush = 1'b0;

    // Test 4: flushed fetches are dropped; following fetch is delivered normally.
    for (int m = 0; m < 3; m++) fetch_flush(m);
    do_vec(vecs[0]);

    // Test 5: reset in WAIT, then a stale memory response.
    drive_edge();
    if_req = 1'b1; if_addr = 16'h0055; mem_ready = 1'b1;
    drive_edge();
    drive_edge();
    if_req = 1'b0; rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    #1;
    chk("rst_wait_outs_zero", all_outs(), 0);
    drive_edge();
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    #1;
    chk("rst_stale_rvalid_outs", all_outs(), 0);
    drive_edge();
    mem_rvalid = 1'b0; mem_rdata = '0;
    // Reset while stalled in ISSUE.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0123; mem_ready = 1'b0;
    drive_edge();
    rst = 1'b1;
    drive_edge();
    rst = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    #1;
    chk("rst_issue_outs_zero", all_outs(), 0);
    drive_edge();
    #1;
    chk("rst_issue_stays_idle", mem_req, 0);

    // Test 6: both requesters held; fetch only wins when the starvation guard is built in.
    mem_ready = 1'b1;
    if_req = 1'b1; if_addr = 16'h0600;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h0700; dm_wdata = 16'h0707;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #2;
      exp_if = Guard && (k == 5);
      chk("starve_if_gnt", if_gnt, exp_if);
      chk("starve_dm_gnt", dm_gnt, !exp_if);
      if (if_gnt) begin
        drive_edge();
        if_req = 1'b0;
        if (exp_if) if_q.push_back(16'h600D);
        mem_rvalid = 1'b1; mem_rdata = 16'h600D;
        drive_edge();
        mem_rvalid = 1'b0; mem_rdata = '0; dm_req = 1'b0;
        break;
      end
      @(posedge clk);
    end
    #1;
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("if_sb_drained", if_q.size(), 0);
    chk("dm_sb_drained", dm_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter
Interface
REQ-001 Parameters SHALL be: ADDR_W, 16, address width; DATA_W, 16, data width; STARVE_LIMIT, 4, consecutive fetch losses before fetch is forced to win.
REQ-002 Ports SHALL be: clk in 1 clock; rst in 1 reset, one clock, synchronous, active-high.
REQ-003 Fetch ports SHALL be: if_req in 1; if_addr in ADDR_W; if_flush in 1; if_gnt out 1; if_rvalid out 1; if_rdata out DATA_W.
REQ-004 Data ports SHALL be: dm_req in 1; dm_we in 1; dm_addr in ADDR_W; dm_wdata in DATA_W; dm_gnt out 1; dm_rvalid out 1; dm_rdata out DATA_W.
REQ-005 Memory ports SHALL be: mem_req out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_ready in 1; mem_rvalid in 1; mem_rdata in DATA_W.
Function
REQ-006 FSM SHALL have states IDLE, ISSUE, WAIT, with at most one transaction outstanding.
REQ-007 IDLE: if any req is high, SHALL register owner, we, addr and wdata of the winner and go to ISSUE next cycle; otherwise stay in IDLE.
REQ-008 Arbitration SHALL give dm priority over if when both requests are high, except as in REQ-020.
REQ-009 ISSUE: mem_req SHALL be 1 and mem_we/addr/wdata SHALL come from the registered values; when mem_ready=1, the owner's gnt SHALL pulse high for that single cycle.
REQ-010 ISSUE with mem_ready=1: a write SHALL go to IDLE and a read SHALL go to WAIT; with mem_ready=0, the FSM SHALL stay in ISSUE and hold all outputs.
REQ-011 WAIT: on mem_rvalid=1, the owner's rvalid SHALL equal 1 and its rdata SHALL equal mem_rdata combinationally in the same cycle, and the FSM SHALL go to IDLE.
REQ-012 Latency: a read with req at cycle 0 and mem_ready=1 SHALL have gnt at cycle 1; with mem_rvalid at cycle 2, rvalid SHALL be at cycle 2; back-to-back issue SHALL be no sooner than IDLE+1.
REQ-013 mem_rvalid in IDLE or ISSUE SHALL be ignored.
REQ-014 Requesters SHALL hold req and their fields stable until gnt; once captured, the registered values SHALL be used.
REQ-015 if_flush=1 while the owner is fetch in ISSUE or WAIT SHALL set a drop flag, and the completing if_rvalid SHALL be suppressed; the transaction SHALL still complete on the memory side.
REQ-016 if_flush in the same cycle as mem_rvalid SHALL suppress that if_rvalid; the drop flag SHALL clear on return to IDLE.
REQ-017 if_flush SHALL have no effect on data-port transactions or in IDLE.
REQ-018 rdata outputs SHALL be 0 whenever the corresponding rvalid is 0.
Reset
REQ-019 rst SHALL force IDLE, clear owner, drop flag and starvation counter, and drive every output to 0 the next cycle, including mid-ISSUE and mid-WAIT; a later stale mem_rvalid SHALL be ignored per REQ-013.
Configuration
REQ-020 With MEM_ARB_STARVE_GUARD_EN defined: a counter SHALL increment on each IDLE decision where if_req=1 and dm wins, and SHALL clear when fetch wins or if_req=0.
REQ-021 With MEM_ARB_STARVE_GUARD_EN defined: when the counter equals STARVE_LIMIT, fetch SHALL win the next IDLE decision.
REQ-022 Without MEM_ARB_STARVE_GUARD_EN: priority SHALL be strict dm-over-if, and no counter logic SHALL exist.
Structure
REQ-023 Package mem_arb_pkg SHALL hold the state enum (IDLE/ISSUE/WAIT), the owner enum (OWN_IF/OWN_DM) and the default ADDR_W/DATA_W constants.
REQ-024 The design SHALL be a single module with no sub-module; the starvation counter SHALL be inline, under the macro.
Verification
REQ-025 Test 1 SHALL check: if_req with if_addr=0x0040, mem_ready=1 at once, mem_rvalid at +1 with rdata=0xBEEF -> if_gnt at cycle 1, if_rvalid=1 with if_rdata=0xBEEF at cycle 2.
REQ-026 Test 2 SHALL check: if_req and dm_req (write, addr 0x0100, wdata 0x1234) together -> dm wins, and mem_we=1, mem_addr=0x0100 in ISSUE, dm_gnt=1, then the fetch issues next.
REQ-027 Test 3 SHALL check: mem_ready held 0 for 3 cycles in ISSUE -> mem_req and fields stable, no gnt until ready.
REQ-028 Test 4 SHALL check: fetch in WAIT, if_flush pulse, then mem_rvalid=1 -> if_rvalid stays 0 and FSM returns to IDLE; the next fetch is delivered normally.
REQ-029 Test 5 SHALL check: rst asserted in WAIT, then mem_rvalid=1 one cycle after release -> all outputs 0 and no rvalid produced.
REQ-030 Test 6 SHALL check, with MEM_ARB_STARVE_GUARD_EN and STARVE_LIMIT=4: dm_req and if_req held continuously -> fetch granted on the 5th arbitration; without the macro, fetch is never granted.
